// File: rtl/adc_spi_pkg.sv
// ---- adc_spi_pkg : shared constants for the 32-bit ADC SPI command protocol  (rev 1.0) ----
`default_nettype none

package adc_spi_pkg;

  localparam int FRAME_W  = 32;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int MOD_MSB  = 26;
  localparam int MOD_LSB  = 25;
  localparam int ADDR_MSB = 24;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_CLRH = 5'b11000;
  localparam logic [4:0] OPC_REAH = 5'b11001;
  localparam logic [4:0] OPC_READ = 5'b10001;
  localparam logic [4:0] OPC_WRIT = 5'b11010;
  localparam logic [4:0] OPC_SETH = 5'b11011;

  localparam logic [1:0] MODF_FULL    = 2'b00;
  localparam logic [1:0] MODF_MS_BYTE = 2'b01;
  localparam logic [1:0] MODF_LS_BYTE = 2'b10;
  localparam logic [1:0] MODF_BAD     = 2'b11;

  localparam logic [8:0] ADDR_DEVICE_ID   = 9'h000;
  localparam logic [8:0] ADDR_RST_PWRCTL  = 9'h004;
  localparam logic [8:0] ADDR_SDI_CTL     = 9'h00C;
  localparam logic [8:0] ADDR_SDO_CTL     = 9'h010;
  localparam logic [8:0] ADDR_DATAOUT_CTL = 9'h014;
  localparam logic [8:0] ADDR_RANGE_SEL   = 9'h018;
  localparam logic [8:0] ADDR_ALARM       = 9'h020;
  localparam logic [8:0] ADDR_ALARM_H_TH  = 9'h024;
  localparam logic [8:0] ADDR_ALARM_L_TH  = 9'h028;

  localparam logic [31:0] RST_RST_PWRCTL  = 32'h0000_0000;
  localparam logic [31:0] RST_SDI_CTL     = 32'h0000_0000;
  localparam logic [31:0] RST_SDO_CTL     = 32'h0000_0000;
  localparam logic [31:0] RST_DATAOUT_CTL = 32'h0000_0000;
  localparam logic [31:0] RST_RANGE_SEL   = 32'h0000_0000;
  localparam logic [31:0] RST_ALARM_H_TH  = 32'h0000_FFFF;
  localparam logic [31:0] RST_ALARM_L_TH  = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } link_state_t;

  // Word-aligned form of a byte address; addr[1:0] never takes part in register selection.
  function automatic logic [8:0] word_addr(input logic [8:0] addr);
    return {addr[8:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_spi_responder_edge_sync.sv
// ---- spi_edge_sync : multi-flop synchronizer with rise/fall detection  (rev 1.0) ----
`default_nettype none

module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Chain resets low so a chip select already asserted at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

`default_nettype wire

// File: rtl/adc_spi_responder.sv
// ---- adc_spi_responder : SPI mode-0 register responder for the ADC command protocol  (rev 1.0) ----
`default_nettype none

module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter logic [15:0] DEV_ID      = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        sdi,
  output logic        sdo,
  input  logic [15:0] sample_data,
  output logic [3:0]  range_sel,
  output logic        frame_done,
  output logic        cmd_err
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic sdi_level, sdi_rise, sdi_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sdi_sync (
    .clk(clk), .rst_n(rst_n), .din(sdi), .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall));

  link_state_t          state, state_next;
  logic [5:0]           bit_cnt;
  logic [FRAME_W-1:0]   rx_shift, tx_shift, pending;
  logic [31:0]          rst_pwrctl, sdi_ctl, sdo_ctl, dataout_ctl, range_reg, alarm_h_th, alarm_l_th;

  logic [4:0]  opc;
  logic [1:0]  modf;
  logic [8:0]  addr;
  logic [15:0] data;

  assign opc  = rx_shift[OPC_MSB:OPC_LSB];
  assign modf = rx_shift[MOD_MSB:MOD_LSB];
  assign addr = rx_shift[ADDR_MSB:ADDR_LSB];
  assign data = rx_shift[DATA_MSB:DATA_LSB];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, sclk_level, cs_level, sdi_rise, sdi_fall, addr[0]};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_next = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  logic        frame_end;
  logic        known, writable, legal, is_read, is_write, frame_ok;
  logic [31:0] cur_word, new_word;
  logic [15:0] cur_half, new_half, rd_half;

  assign frame_end = (state == ST_SHIFT) && cs_rise;

  always_comb begin
    known    = 1'b1;
    writable = 1'b0;
    cur_word = 32'h0;
    case (word_addr(addr))
      ADDR_DEVICE_ID:   cur_word = {DEV_ID, 16'h0};
      ADDR_RST_PWRCTL:  begin cur_word = rst_pwrctl;  writable = 1'b1; end
      ADDR_SDI_CTL:     begin cur_word = sdi_ctl;     writable = 1'b1; end
      ADDR_SDO_CTL:     begin cur_word = sdo_ctl;     writable = 1'b1; end
      ADDR_DATAOUT_CTL: begin cur_word = dataout_ctl; writable = 1'b1; end
      ADDR_RANGE_SEL:   begin cur_word = range_reg;   writable = 1'b1; end
      ADDR_ALARM:       cur_word = 32'h0;
      ADDR_ALARM_H_TH:  begin cur_word = alarm_h_th;  writable = 1'b1; end
      ADDR_ALARM_L_TH:  begin cur_word = alarm_l_th;  writable = 1'b1; end
      default:          known = 1'b0;
    endcase

    cur_half = addr[1] ? cur_word[31:16] : cur_word[15:0];
    new_half = cur_half;
    rd_half  = cur_half;
    legal    = 1'b1;
    is_read  = 1'b0;
    is_write = 1'b0;
    case (opc)
      OPC_NOP:  ;
      OPC_READ: is_read = 1'b1;
      OPC_REAH: begin is_read = 1'b1; rd_half = cur_word[31:16]; end
      OPC_CLRH: begin is_write = 1'b1; new_half = cur_half & ~data; end
      OPC_SETH: begin is_write = 1'b1; new_half = cur_half | data; end
      OPC_WRIT: begin
        case (modf)
          MODF_FULL:    begin is_write = 1'b1; new_half = data; end
          MODF_MS_BYTE: begin is_write = 1'b1; new_half = {data[15:8], cur_half[7:0]}; end
          MODF_LS_BYTE: begin is_write = 1'b1; new_half = {cur_half[15:8], data[7:0]}; end
          MODF_BAD:     legal = 1'b0;
          default:      legal = 1'b0;
        endcase
      end
      default:  legal = 1'b0;
    endcase

    new_word = addr[1] ? {new_half, cur_word[15:0]} : {cur_word[31:16], new_half};
    // Writes to read-only locations succeed silently; unmapped ones are errors.
    frame_ok = (bit_cnt == 6'd32) && legal && !(is_write && !known);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      pending    <= '0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      if (state == ST_IDLE && cs_fall) begin
        bit_cnt  <= '0;
        tx_shift <= pending;
      end else if (state == ST_SHIFT && !cs_rise) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[FRAME_W-2:0], sdi_level};
          if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
        end
        if (sclk_fall) tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
      end
      if (frame_end) begin
        frame_done <= frame_ok;
        cmd_err    <= !frame_ok;
        pending    <= (frame_ok && is_read) ? {rd_half, 16'h0} : {sample_data, 16'h0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_pwrctl  <= RST_RST_PWRCTL;
      sdi_ctl     <= RST_SDI_CTL;
      sdo_ctl     <= RST_SDO_CTL;
      dataout_ctl <= RST_DATAOUT_CTL;
      range_reg   <= RST_RANGE_SEL;
      alarm_h_th  <= RST_ALARM_H_TH;
      alarm_l_th  <= RST_ALARM_L_TH;
    end else if (frame_end && frame_ok && is_write && writable) begin
      case (word_addr(addr))
        ADDR_RST_PWRCTL:  rst_pwrctl  <= new_word;
        ADDR_SDI_CTL:     sdi_ctl     <= new_word;
        ADDR_SDO_CTL:     sdo_ctl     <= new_word;
        ADDR_DATAOUT_CTL: dataout_ctl <= new_word;
        ADDR_RANGE_SEL:   range_reg   <= new_word;
        ADDR_ALARM_H_TH:  alarm_h_th  <= new_word;
        ADDR_ALARM_L_TH:  alarm_l_th  <= new_word;
        default:          ;
      endcase
    end
  end

  assign sdo       = (state == ST_SHIFT) & tx_shift[FRAME_W-1];
  assign range_sel = range_reg[3:0];

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
// ---- tb_adc_spi_responder : directed self-checking bench for adc_spi_responder  (rev 1.0) ----
`default_nettype none

module tb_adc_spi_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [15:0] sample_data = 16'h5A5A;
  logic [3:0]  range_sel;
  logic        frame_done;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] resp;
  int          nd, ne;

  adc_spi_responder #(.DEV_ID(16'h1234), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
    .sample_data(sample_data), .range_sel(range_sel), .frame_done(frame_done), .cmd_err(cmd_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] md,
                                     input logic [8:0] a, input logic [15:0] d);
    return {op, md, a, d};
  endfunction

  task automatic spi_xfer(input logic [31:0] cmd, input int nbits, output logic [31:0] r,
                          output int n_done, output int n_err);
    r = '0; n_done = 0; n_err = 0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = cmd[31-i];
      repeat (HALF) @(negedge clk);
      r = {r[30:0], sdo};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (cmd_err) n_err++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    checks++; if (range_sel !== 4'h0) begin errors++; $display("FAIL reset_range_sel: got %h want 0", range_sel); end
  endtask

  task automatic test_write;
    spi_xfer(mk(5'b11010, 2'b00, 9'h018, 16'h0005), 32, resp, nd, ne);
    checks++; if (resp !== 32'h0) begin errors++; $display("FAIL write_first_resp: got %h want 00000000", resp); end
    checks++; if (range_sel !== 4'h5) begin errors++; $display("FAIL write_range_sel: got %h want 5", range_sel); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL write_frame_done_count: got %0d want 1", nd); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL write_cmd_err_count: got %0d want 0", ne); end
  endtask

  task automatic test_read;
    spi_xfer(mk(5'b10001, 2'b00, 9'h018, 16'h0000), 32, resp, nd, ne);
    checks++; if (resp !== 32'h5A5A_0000) begin errors++; $display("FAIL read_prev_sample: got %h want 5a5a0000", resp); end
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'h0005_0000) begin errors++; $display("FAIL read_range_resp: got %h want 00050000", resp); end
  endtask

  task automatic test_set_clr;
    spi_xfer(mk(5'b11011, 2'b00, 9'h018, 16'h000A), 32, resp, nd, ne);
    spi_xfer(mk(5'b11000, 2'b00, 9'h018, 16'h0001), 32, resp, nd, ne);
    checks++; if (range_sel !== 4'hE) begin errors++; $display("FAIL setclr_range_sel: got %h want e", range_sel); end
    spi_xfer(mk(5'b10001, 2'b00, 9'h018, 16'h0000), 32, resp, nd, ne);
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'h000E_0000) begin errors++; $display("FAIL setclr_read: got %h want 000e0000", resp); end
  endtask

  task automatic test_abort;
    sample_data = 16'hABCD;
    spi_xfer(mk(5'b11010, 2'b00, 9'h018, 16'h0003), 20, resp, nd, ne);
    checks++; if (ne !== 1) begin errors++; $display("FAIL abort_cmd_err: got %0d want 1", ne); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_frame_done: got %0d want 0", nd); end
    checks++; if (range_sel !== 4'hE) begin errors++; $display("FAIL abort_range_sel: got %h want e", range_sel); end
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'hABCD_0000) begin errors++; $display("FAIL abort_next_resp: got %h want abcd0000", resp); end
  endtask

  task automatic test_dev_id;
    spi_xfer(mk(5'b11001, 2'b00, 9'h000, 16'h0000), 32, resp, nd, ne);
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'h1234_0000) begin errors++; $display("FAIL devid_read: got %h want 12340000", resp); end
    spi_xfer(mk(5'b11010, 2'b00, 9'h002, 16'hFFFF), 32, resp, nd, ne);
    checks++; if (ne !== 0) begin errors++; $display("FAIL devid_write_err: got %0d want 0", ne); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL devid_write_done: got %0d want 1", nd); end
    spi_xfer(mk(5'b11001, 2'b00, 9'h000, 16'h0000), 32, resp, nd, ne);
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'h1234_0000) begin errors++; $display("FAIL devid_unchanged: got %h want 12340000", resp); end
  endtask

  task automatic test_illegal;
    spi_xfer(mk(5'b11010, 2'b11, 9'h018, 16'h0000), 32, resp, nd, ne);
    checks++; if (ne !== 1 || nd !== 0) begin errors++; $display("FAIL illegal_modifier: got err=%0d done=%0d want err=1 done=0", ne, nd); end
    checks++; if (range_sel !== 4'hE) begin errors++; $display("FAIL illegal_modifier_range: got %h want e", range_sel); end
    spi_xfer(mk(5'b11010, 2'b00, 9'h01C, 16'h0001), 32, resp, nd, ne);
    checks++; if (ne !== 1) begin errors++; $display("FAIL illegal_addr_write: got %0d want 1", ne); end
    spi_xfer(mk(5'b11111, 2'b00, 9'h018, 16'h0000), 32, resp, nd, ne);
    checks++; if (ne !== 1) begin errors++; $display("FAIL illegal_opcode: got %0d want 1", ne); end
    spi_xfer(mk(5'b10001, 2'b00, 9'h030, 16'h0000), 32, resp, nd, ne);
    checks++; if (ne !== 0 || nd !== 1) begin errors++; $display("FAIL unmapped_read_flags: got err=%0d done=%0d want err=0 done=1", ne, nd); end
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'h0) begin errors++; $display("FAIL unmapped_read_value: got %h want 00000000", resp); end
  endtask

  task automatic test_reset_midframe;
    int pulses;
    logic [31:0] cmd;
    cmd = mk(5'b11010, 2'b00, 9'h018, 16'h0007);
    pulses = 0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      sdi = cmd[31-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_done || cmd_err) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", pulses); end
    checks++; if (range_sel !== 4'h0 || sdo !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got range=%h sdo=%b want 0 0", range_sel, sdo); end
    spi_xfer(mk(5'b11010, 2'b00, 9'h018, 16'h0009), 32, resp, nd, ne);
    checks++; if (resp !== 32'h0) begin errors++; $display("FAIL rstmid_pending: got %h want 00000000", resp); end
    checks++; if (range_sel !== 4'h9 || nd !== 1 || ne !== 0) begin errors++; $display("FAIL rstmid_rewrite: got range=%h done=%0d err=%0d want 9 1 0", range_sel, nd, ne); end
    spi_xfer(mk(5'b10001, 2'b00, 9'h024, 16'h0000), 32, resp, nd, ne);
    spi_xfer(mk(5'b10001, 2'b00, 9'h026, 16'h0000), 32, resp, nd, ne);
    checks++; if (resp !== 32'hFFFF_0000) begin errors++; $display("FAIL rstmid_alarm_h_low: got %h want ffff0000", resp); end
    spi_xfer(32'h0, 32, resp, nd, ne);
    checks++; if (resp !== 32'h0) begin errors++; $display("FAIL rstmid_alarm_h_high: got %h want 00000000", resp); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_set_clr();
    test_abort();
    test_dev_id();
    test_illegal();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI responder, mode 0 (CPOL=0, CPHA=0). It is the device-side end of the 32-bit ADC command protocol issued by the team's ADC SPI command master.
- Receives command frames on sdi, decodes them, and updates a small register map. Each frame's response is returned on sdo during the following frame.
- Used in two places: as a loop-back/bench target for the master, and as a register front-end when the converter is emulated in fabric.

Parameters:
- DEV_ID, 16'h0000, value returned from DEVICE_ID high half.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/sdi (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst_n  in  1  reset, synchronous, active-low.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- cs_n  in  1  SPI chip select, active-low.
- sdi  in  1  serial command data, MSB first.
- sdo  out  1  serial response data, MSB first.
- sample_data  in  16  conversion result from emulated converter.
- range_sel  out  4  RANGE_SEL[3:0] to the analog/emulation path.
- frame_done  out  1  one-clk pulse; a valid 32-bit frame was decoded.
- cmd_err  out  1  one-clk pulse; the frame was aborted or carried an illegal opcode/address.

Behaviour:
- Frame layout: [31:27] opcode, [26:25] modifier, [24:16] addr (byte address), [15:0] data.
- Opcodes:
  - NOP 00000
  - CLRH 11000: reg_half &= ~data
  - REAH 11001: read high half
  - READ 10001: read half selected by addr[1]
  - WRIT 11010: modifier 00 = full half write, 01 = MS byte only, 10 = LS byte only, 11 = illegal
  - SETH 11011: reg_half |= data
- Register map: 32-bit registers addressed by addr[8:2]; addr[1] selects the half (1 = [31:16], 0 = [15:0]); addr[0] is ignored.
  - 0x00 DEVICE_ID, RO, {DEV_ID, 16'h0}.
  - 0x04 RST_PWRCTL, reset 0.
  - 0x0C SDI_CTL, reset 0.
  - 0x10 SDO_CTL, reset 0.
  - 0x14 DATAOUT_CTL, reset 0.
  - 0x18 RANGE_SEL, reset 0; range_sel = bits [3:0].
  - 0x20 ALARM, RO, returns 0.
  - 0x24 ALARM_H_TH, reset 32'h0000_FFFF.
  - 0x28 ALARM_L_TH, reset 0.
  - Any other address: a write or read-modify-write raises cmd_err; a read returns 0.
- Synchronization: sclk, cs_n and sdi each pass through SYNC_STAGES flops. Edges are detected on the synchronized copies.
- Timing requirement: sclk high and low times must each be at least SYNC_STAGES+1 clk periods; cs_n setup to first sclk rise must be at least 2 clk periods.
- cs_n fall detected:
  - bit_cnt cleared.
  - tx_shift loaded from the pending response.
  - sdo = tx_shift[31] on the next clk.
- sclk rise while cs_n low: rx_shift <= {rx_shift[30:0], sdi}; bit_cnt increments, saturating at 33.
- sclk fall while cs_n low: tx_shift shifts left with 0 fill; sdo follows tx_shift[31]. After 32 bits, sdo = 0.
- cs_n rise detected:
  - bit_cnt == 32: decode rx_shift. The register update and the frame_done pulse occur 1 clk after detection.
  - bit_cnt != 32, or an illegal opcode/modifier: cmd_err pulse; no register change.
- Pending response, latched at cs_n rise:
  - Valid READ/REAH: {reg_half, 16'h0}.
  - Every other case, including aborted frames: {sample_data, 16'h0}.
- Write-to-RO: ignored silently (no cmd_err).
- cs_n high: sdo = 0; sclk edges are ignored.
- Reset (any time, including mid-frame):
  - sdo = 0, frame_done = 0, cmd_err = 0.
  - bit_cnt = 0, shift registers = 0, pending response = 0.
  - All registers return to their defaults; range_sel = 0.
  - A frame in progress is discarded. The next cs_n fall starts cleanly.
  - After reset, if cs_n is already low, nothing is decoded until cs_n goes high and then falls again.

Decomposition:
- Shared package adc_spi_pkg:
  - opcode constants NOP/CLRH/REAH/READ/WRIT/SETH
  - modifier constants
  - register address constants
  - register reset values
  - field positions OPC_MSB/LSB, ADDR_MSB/LSB, DATA_MSB/LSB
  - FRAME_W = 32
- The same package is reused by the master.
- One sub-module, spi_edge_sync: synchronizer plus rise/fall detect. Instantiated once per input and parameterized by SYNC_STAGES.
- Register file and decoder stay in the top level.

Test Plan:
- WRIT {11010,00,9'h018,16'h0005} -> one clk after cs_n rise detect: range_sel = 4'h5, frame_done pulses once.
- READ {10001,00,9'h018,16'h0} followed by a NOP frame -> sdo during the NOP frame = 32'h0005_0000.
- SETH 9'h018 data 16'h000A, then CLRH data 16'h0001, then READ -> RANGE_SEL low half = 16'h000E.
- Frame of 20 sclk cycles, then cs_n high -> cmd_err pulse, range_sel unchanged. The next frame's sdo = {sample_data, 16'h0}, e.g. 32'hABCD_0000 with sample_data = 16'hABCD.
- REAH addr 9'h000 with DEV_ID = 16'h1234, followed by NOP -> sdo = 32'h1234_0000. WRIT to 9'h000 -> DEVICE_ID unchanged, no cmd_err.
- rst_n low at bit 15 of a WRIT frame, released with cs_n high -> all outputs 0 and registers at defaults. A following full WRIT decodes correctly.
